// File: rtl/parser_pkg.sv
// Shared widths, table-entry and beat records, and the key-extraction helper
// for the programmable header-parse stage.
package parser_pkg;

  localparam int MSG_W   = 2048;
  localparam int KEY_W   = 16;
  localparam int OFF_W   = 12;
  localparam int ENTRIES = 8;

  // One ternary match-table entry: a set mask bit means "this key bit must match".
  typedef struct packed {
    logic             vld;
    logic [KEY_W-1:0] key;
    logic [KEY_W-1:0] mask;
    logic [OFF_W-1:0] adv;
  } parser_entry_t;

  // One header-vector beat as it travels between stages.
  typedef struct packed {
    logic [MSG_W-1:0] message;
    logic [OFF_W-1:0] offset;
    logic [KEY_W-1:0] key;
    logic             done;
  } parser_beat_t;

  // Pull KEY_W bits starting at wire bit pos (bit 0 is the message MSB).
  // Caller guarantees pos + KEY_W <= MSG_W.
  function automatic logic [KEY_W-1:0] extract_key(input logic [MSG_W-1:0] msg,
                                                   input logic [OFF_W:0]   pos);
    logic [MSG_W-1:0] sh;
    sh = msg >> ((OFF_W+1)'(MSG_W - KEY_W) - pos);
    return sh[KEY_W-1:0];
  endfunction

endpackage

// File: rtl/parser_tcam.sv
// Run-time-writable ternary match table with lowest-index-wins priority match.
module parser_tcam #(
  parameter int KEY_W   = 16,
  parameter int OFF_W   = 12,
  parameter int ENTRIES = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cfg_we,
  input  logic [$clog2(ENTRIES)-1:0] cfg_addr,
  input  logic                       cfg_vld,
  input  logic [KEY_W-1:0]           cfg_key,
  input  logic [KEY_W-1:0]           cfg_mask,
  input  logic [OFF_W-1:0]           cfg_adv,
  input  logic [KEY_W-1:0]           key,
  output logic                       hit,
  output logic [$clog2(ENTRIES)-1:0] hit_idx,
  output logic [OFF_W-1:0]           adv
);
  import parser_pkg::*;

  localparam int IDX_W = $clog2(ENTRIES);

  parser_entry_t tbl [ENTRIES];

  // Entry registers: a write lands at the clock edge, so a lookup in the same
  // cycle still sees the previous contents.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) tbl[i] <= '0;
    end else if (cfg_we) begin
      tbl[cfg_addr] <= '{vld: cfg_vld, key: cfg_key, mask: cfg_mask, adv: cfg_adv};
    end
  end

  // Priority match: scan from the top so the lowest matching index is left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    adv     = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (tbl[i].vld && (((key ^ tbl[i].key) & tbl[i].mask) == '0)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
        adv     = tbl[i].adv;
      end
    end
  end

endmodule

// File: rtl/parser_stage.sv
// Single-header parse stage: table lookup (S1), offset advance and next-key
// extraction (S2), elastic valid/ready handshake and saturating statistics.
module parser_stage #(
  parameter int MSG_W   = 2048,
  parameter int KEY_W   = 16,
  parameter int ENTRIES = 8,
  parameter int OFF_W   = 12,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [MSG_W-1:0]           in_message,
  input  logic [OFF_W-1:0]           in_offset,
  input  logic [KEY_W-1:0]           in_key,
  input  logic                       in_done,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [MSG_W-1:0]           out_message,
  output logic [OFF_W-1:0]           out_offset,
  output logic [KEY_W-1:0]           out_key,
  output logic                       out_done,
  output logic                       out_hit,
  output logic                       out_err,
  output logic [$clog2(ENTRIES)-1:0] out_hit_idx,
  input  logic                       cfg_we,
  input  logic [$clog2(ENTRIES)-1:0] cfg_addr,
  input  logic                       cfg_vld,
  input  logic [KEY_W-1:0]           cfg_key,
  input  logic [KEY_W-1:0]           cfg_mask,
  input  logic [OFF_W-1:0]           cfg_adv,
  output logic [CNT_W-1:0]           hit_cnt,
  output logic [CNT_W-1:0]           miss_cnt
);
  import parser_pkg::*;

  localparam int IDX_W = $clog2(ENTRIES);

  logic             s1_adv, s2_adv;
  logic             tcam_hit;
  logic [IDX_W-1:0] tcam_idx;
  logic [OFF_W-1:0] tcam_adv;

  parser_beat_t     beat_p1;
  logic             vld_p1, hit_p1;
  logic [IDX_W-1:0] idx_p1;
  logic [OFF_W-1:0] adv_p1;

  logic [OFF_W:0]   pos_p1;
  logic             range_err_p1;
  logic [OFF_W-1:0] nxt_offset;
  logic [KEY_W-1:0] nxt_key;
  logic             nxt_done, nxt_hit, nxt_err;
  logic [IDX_W-1:0] nxt_idx;

  logic             vld_p2, cnt_p2, done_p2, hit_p2, err_p2;
  logic [MSG_W-1:0] msg_p2;
  logic [OFF_W-1:0] offset_p2;
  logic [KEY_W-1:0] key_p2;
  logic [IDX_W-1:0] idx_p2;

  parser_tcam #(.KEY_W(KEY_W), .OFF_W(OFF_W), .ENTRIES(ENTRIES)) u_tcam (
    .clk      (clk),
    .reset    (reset),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_vld  (cfg_vld),
    .cfg_key  (cfg_key),
    .cfg_mask (cfg_mask),
    .cfg_adv  (cfg_adv),
    .key      (in_key),
    .hit      (tcam_hit),
    .hit_idx  (tcam_idx),
    .adv      (tcam_adv)
  );

  // Each stage moves when its slot is empty or the slot ahead is draining.
  assign s2_adv   = !vld_p2 || out_ready;
  assign s1_adv   = !vld_p1 || s2_adv;
  assign in_ready = s1_adv;

  // ---- S1: lookup; a beat already marked done bypasses the table ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1  <= 1'b0;
      beat_p1 <= '0;
      hit_p1  <= 1'b0;
      idx_p1  <= '0;
      adv_p1  <= '0;
    end else if (s1_adv) begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        beat_p1 <= '{message: in_message, offset: in_offset, key: in_key, done: in_done};
        hit_p1  <= tcam_hit && !in_done;
        idx_p1  <= in_done ? '0 : tcam_idx;
        adv_p1  <= tcam_adv;
      end
    end
  end

  // Advance arithmetic is one bit wider so an overflow past the offset range is visible.
  assign pos_p1       = {1'b0, beat_p1.offset} + {1'b0, adv_p1};
  assign range_err_p1 = pos_p1[OFF_W] || ((int'(pos_p1) + KEY_W) > MSG_W);

  // Next-header fields: hit advances, miss finishes parsing, range error finishes with err.
  always_comb begin
    nxt_offset = beat_p1.offset;
    nxt_key    = beat_p1.key;
    nxt_done   = beat_p1.done;
    nxt_hit    = 1'b0;
    nxt_err    = 1'b0;
    nxt_idx    = '0;
    if (!beat_p1.done) begin
      if (!hit_p1) begin
        nxt_done = 1'b1;
      end else begin
        nxt_hit = 1'b1;
        nxt_idx = idx_p1;
        if (range_err_p1) begin
          nxt_err  = 1'b1;
          nxt_done = 1'b1;
        end else begin
          nxt_offset = pos_p1[OFF_W-1:0];
          nxt_key    = extract_key(beat_p1.message, pos_p1);
          nxt_done   = 1'b0;
        end
      end
    end
  end

  // ---- S2: advance result; held while downstream stalls ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p2    <= 1'b0;
      cnt_p2    <= 1'b0;
      msg_p2    <= '0;
      offset_p2 <= '0;
      key_p2    <= '0;
      done_p2   <= 1'b0;
      hit_p2    <= 1'b0;
      err_p2    <= 1'b0;
      idx_p2    <= '0;
    end else if (s2_adv) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        cnt_p2    <= !beat_p1.done;
        msg_p2    <= beat_p1.message;
        offset_p2 <= nxt_offset;
        key_p2    <= nxt_key;
        done_p2   <= nxt_done;
        hit_p2    <= nxt_hit;
        err_p2    <= nxt_err;
        idx_p2    <= nxt_idx;
      end
    end
  end

  // Statistics count beats leaving the stage that were still being parsed on entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (vld_p2 && out_ready && cnt_p2) begin
      if (hit_p2) begin
        if (hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
      end else begin
        if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
      end
    end
  end

  assign out_valid   = vld_p2;
  assign out_message = msg_p2;
  assign out_offset  = offset_p2;
  assign out_key     = key_p2;
  assign out_done    = done_p2;
  assign out_hit     = hit_p2;
  assign out_err     = err_p2;
  assign out_hit_idx = idx_p2;

endmodule

// File: tb/tb_parser_stage.sv
// Bench for parser_stage: table-driven beats checked through a scoreboard queue,
// plus hand sequences for latency, back-pressure, same-cycle table write and reset.
module tb_parser_stage;

  localparam int MSG_W = 2048;
  localparam int KEY_W = 16;
  localparam int OFF_W = 12;
  localparam int CNT_W = 16;
  localparam int IDX_W = 3;

  logic             clk;
  logic             reset;
  logic             in_valid, in_ready;
  logic [MSG_W-1:0] in_message;
  logic [OFF_W-1:0] in_offset;
  logic [KEY_W-1:0] in_key;
  logic             in_done;
  logic             out_valid, out_ready;
  logic [MSG_W-1:0] out_message;
  logic [OFF_W-1:0] out_offset;
  logic [KEY_W-1:0] out_key;
  logic             out_done, out_hit, out_err;
  logic [IDX_W-1:0] out_hit_idx;
  logic             cfg_we;
  logic [IDX_W-1:0] cfg_addr;
  logic             cfg_vld;
  logic [KEY_W-1:0] cfg_key, cfg_mask;
  logic [OFF_W-1:0] cfg_adv;
  logic [CNT_W-1:0] hit_cnt, miss_cnt;

  parser_stage dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_message(in_message),
    .in_offset(in_offset), .in_key(in_key), .in_done(in_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_message(out_message),
    .out_offset(out_offset), .out_key(out_key), .out_done(out_done),
    .out_hit(out_hit), .out_err(out_err), .out_hit_idx(out_hit_idx),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_vld(cfg_vld),
    .cfg_key(cfg_key), .cfg_mask(cfg_mask), .cfg_adv(cfg_adv),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  typedef struct {
    logic [MSG_W-1:0] msg;
    logic [OFF_W-1:0] off;
    logic [KEY_W-1:0] key;
    logic             done, hit, err;
    logic [IDX_W-1:0] idx;
  } exp_t;

  typedef struct {
    logic [OFF_W-1:0] off;
    logic [KEY_W-1:0] key;
    logic             done;
    logic             alt;
    logic [OFF_W-1:0] e_off;
    logic [KEY_W-1:0] e_key;
    logic             e_done, e_hit, e_err;
    logic [IDX_W-1:0] e_idx;
  } vec_t;

  exp_t             sbq[$];
  exp_t             mon_e;
  int               total = 0;
  int               bad   = 0;
  int               beat_no = 0;
  logic [MSG_W-1:0] msg_a, msg_b;
  vec_t             tv[9];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [MSG_W-1:0] put16(input logic [MSG_W-1:0] m, input int pos,
                                             input logic [KEY_W-1:0] k);
    logic [MSG_W-1:0] r;
    r = m;
    r[MSG_W-1-pos -: 16] = k;
    return r;
  endfunction

  function automatic vec_t mk(input int off, input logic [15:0] key, input logic done,
                              input logic alt, input int e_off, input logic [15:0] e_key,
                              input logic e_done, input logic e_hit, input logic e_err,
                              input int e_idx);
    vec_t v;
    v.off = OFF_W'(off); v.key = key; v.done = done; v.alt = alt;
    v.e_off = OFF_W'(e_off); v.e_key = e_key; v.e_done = e_done;
    v.e_hit = e_hit; v.e_err = e_err; v.e_idx = IDX_W'(e_idx);
    return v;
  endfunction

  function automatic exp_t mkexp(input logic [MSG_W-1:0] m, input int off, input logic [15:0] key,
                                 input logic done, input logic hit, input logic err, input int idx);
    exp_t e;
    e.msg = m; e.off = OFF_W'(off); e.key = key; e.done = done;
    e.hit = hit; e.err = err; e.idx = IDX_W'(idx);
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  task automatic cfg_write(input int a, input logic v, input logic [15:0] k,
                           input logic [15:0] m, input int adv);
    cfg_we = 1'b1; cfg_addr = a[IDX_W-1:0]; cfg_vld = v;
    cfg_key = k; cfg_mask = m; cfg_adv = OFF_W'(adv);
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  // Offer one beat; the expected result is queued only once the handshake happens.
  task automatic send(input logic [MSG_W-1:0] m, input logic [OFF_W-1:0] off,
                      input logic [KEY_W-1:0] key, input logic done, input exp_t e);
    int   waited;
    logic acc;
    in_message = m; in_offset = off; in_key = key; in_done = done; in_valid = 1'b1;
    waited = 0;
    acc = 1'b0;
    while (!acc && waited < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      waited++;
    end
    in_valid = 1'b0;
    if (acc) sbq.push_back(e);
    else chk("send_timeout", 32'(acc), 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (sbq.size() != 0) begin
      chk("drain_timeout", 32'(sbq.size()), 32'd0);
      sbq.delete();
    end
    @(posedge clk); #1;
  endtask

  // Output monitor: each completed handshake is compared with the oldest queued expectation.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_beat: got off=%0h key=%0h with no beat outstanding",
                 out_offset, out_key);
      end else begin
        mon_e = sbq.pop_front();
        if (out_message !== mon_e.msg || out_offset !== mon_e.off || out_key !== mon_e.key ||
            out_done !== mon_e.done || out_hit !== mon_e.hit || out_err !== mon_e.err ||
            out_hit_idx !== mon_e.idx) begin
          bad++;
          $display("FAIL beat%0d (got/want): off=%0h/%0h key=%0h/%0h done=%0b/%0b hit=%0b/%0b err=%0b/%0b idx=%0d/%0d msg_same=%0b",
                   beat_no, out_offset, mon_e.off, out_key, mon_e.key, out_done, mon_e.done,
                   out_hit, mon_e.hit, out_err, mon_e.err, out_hit_idx, mon_e.idx,
                   out_message === mon_e.msg);
        end
      end
      beat_no++;
    end
  end

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_message = '0; in_offset = '0; in_key = '0;
    in_done = 1'b0; out_ready = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_vld = 1'b0;
    cfg_key = '0; cfg_mask = '0; cfg_adv = '0;

    for (int w = 0; w < MSG_W / 32; w++) msg_a[w*32 +: 32] = $urandom;
    msg_a = put16(msg_a, 96,   16'h8100);
    msg_a = put16(msg_a, 112,  16'h5555);
    msg_a = put16(msg_a, 128,  16'h0800);
    msg_a = put16(msg_a, 144,  16'h2468);
    msg_a = put16(msg_a, 208,  16'h1234);
    msg_a = put16(msg_a, 316,  16'h4321);
    msg_a = put16(msg_a, 2032, 16'hBEEF);
    msg_b = ~msg_a;

    //            off  key       dn alt  e_off e_key     e_dn hit err idx
    tv[0] = mk(96,  16'h8100, 0, 0, 128,  16'h0800, 0, 1, 0, 0);
    tv[1] = mk(128, 16'h0800, 0, 0, 208,  16'h1234, 0, 1, 0, 1);
    tv[2] = mk(96,  16'h8847, 0, 0, 112,  16'h5555, 0, 1, 0, 2);
    tv[3] = mk(96,  16'h86DD, 0, 0, 96,   16'h86DD, 1, 0, 0, 0);
    tv[4] = mk(96,  16'h8100, 1, 1, 96,   16'h8100, 1, 0, 0, 0);
    tv[5] = mk(96,  16'h9999, 0, 0, 96,   16'h9999, 1, 1, 1, 3);
    tv[6] = mk(96,  16'h7777, 0, 0, 96,   16'h7777, 1, 1, 1, 7);
    tv[7] = mk(96,  16'h6666, 0, 0, 2032, 16'hBEEF, 0, 1, 0, 6);
    tv[8] = mk(300, 16'h88AB, 0, 0, 316,  16'h4321, 0, 1, 0, 2);

    // Reset state
    #12;
    chk("rst_out_valid_async", 32'(out_valid), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_hit_cnt", 32'(hit_cnt), 32'd0);
    chk("rst_miss_cnt", 32'(miss_cnt), 32'd0);
    chk("rst_out_offset", 32'(out_offset), 32'd0);
    chk("rst_out_key", 32'(out_key), 32'd0);

    cfg_write(0, 1'b1, 16'h8100, 16'hFFFF, 32);
    cfg_write(1, 1'b1, 16'h0800, 16'hFFFF, 80);
    cfg_write(2, 1'b1, 16'h8800, 16'hFF00, 16);
    cfg_write(3, 1'b1, 16'h9999, 16'hFFFF, 4000);
    cfg_write(5, 1'b1, 16'h8847, 16'hFFFF, 32);
    cfg_write(6, 1'b1, 16'h6666, 16'hFFFF, 1936);
    cfg_write(7, 1'b1, 16'h7777, 16'hFFFF, 1944);

    // Latency: beat presented in cycle n is valid at the output in cycle n+2
    send(msg_a, 12'd96, 16'h8100, 1'b0, mkexp(msg_a, 128, 16'h0800, 0, 1, 0, 0));
    chk("lat_not_yet", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("lat_valid", 32'(out_valid), 32'd1);
    drain();
    chk("lat_hit_cnt", 32'(hit_cnt), 32'd1);

    // Table vectors, streamed back to back
    for (int i = 0; i < 9; i++) begin
      send(tv[i].alt ? msg_b : msg_a, tv[i].off, tv[i].key, tv[i].done,
           mkexp(tv[i].alt ? msg_b : msg_a, int'(tv[i].e_off), tv[i].e_key, tv[i].e_done,
                 tv[i].e_hit, tv[i].e_err, int'(tv[i].e_idx)));
    end
    drain();
    chk("tbl_hit_cnt", 32'(hit_cnt), 32'd8);
    chk("tbl_miss_cnt", 32'(miss_cnt), 32'd1);

    // Back-pressure: two beats fill the pipe, the rest wait until the stall lifts
    out_ready = 1'b0;
    send(msg_a, 12'd96, 16'h8100, 1'b0, mkexp(msg_a, 128, 16'h0800, 0, 1, 0, 0));
    send(msg_a, 12'd96, 16'h8847, 1'b0, mkexp(msg_a, 112, 16'h5555, 0, 1, 0, 2));
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    fork
      begin
        send(msg_a, 12'd96, 16'h86DD, 1'b0, mkexp(msg_a, 96, 16'h86DD, 1, 0, 0, 0));
        send(msg_a, 12'd96, 16'h6666, 1'b0, mkexp(msg_a, 2032, 16'hBEEF, 0, 1, 0, 6));
      end
      begin
        for (int c = 0; c < 5; c++) begin
          chk("bp_hold", {out_valid, out_hit, 2'b0, out_offset, out_key},
              {1'b1, 1'b1, 2'b0, 12'd128, 16'h0800});
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_hit_cnt", 32'(hit_cnt), 32'd11);
    chk("bp_miss_cnt", 32'(miss_cnt), 32'd2);

    // Table write coinciding with a capture: that capture sees the old (empty) entry
    in_message = msg_a; in_offset = 12'd96; in_key = 16'hABCD; in_done = 1'b0; in_valid = 1'b1;
    cfg_we = 1'b1; cfg_addr = 3'd4; cfg_vld = 1'b1; cfg_key = 16'hABCD;
    cfg_mask = 16'hFFFF; cfg_adv = 12'd48;
    @(negedge clk);
    chk("wr_same_in_ready", 32'(in_ready), 32'd1);
    sbq.push_back(mkexp(msg_a, 96, 16'hABCD, 1, 0, 0, 0));
    @(posedge clk); #1;
    cfg_we = 1'b0; in_valid = 1'b0;
    send(msg_a, 12'd96, 16'hABCD, 1'b0, mkexp(msg_a, 144, 16'h2468, 0, 1, 0, 4));
    drain();
    chk("wr_hit_cnt", 32'(hit_cnt), 32'd12);
    chk("wr_miss_cnt", 32'(miss_cnt), 32'd3);

    // Reset mid-stream: in-flight beats vanish, counters and table clear
    out_ready = 1'b0;
    send(msg_a, 12'd96, 16'h8100, 1'b0, mkexp(msg_a, 128, 16'h0800, 0, 1, 0, 0));
    send(msg_a, 12'd96, 16'h8847, 1'b0, mkexp(msg_a, 112, 16'h5555, 0, 1, 0, 2));
    chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_hit_cnt", 32'(hit_cnt), 32'd0);
    chk("mid_rst_miss_cnt", 32'(miss_cnt), 32'd0);
    sbq.delete();
    @(posedge clk); #3;
    reset = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    send(msg_a, 12'd96, 16'h8100, 1'b0, mkexp(msg_a, 96, 16'h8100, 1, 0, 0, 0));
    drain();
    chk("post_rst_miss_cnt", 32'(miss_cnt), 32'd1);
    chk("post_rst_hit_cnt", 32'(hit_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
